// File: rtl/usb_rx_crc16_filter_if.sv
// UTMI receive, packet-FIFO and statistics signals of usb_rx_crc16_filter.
// master = UTMI/FIFO environment side, slave = the filter.
interface usb_rx_crc16_filter_if;
  logic        rx_active;
  logic        rx_valid;
  logic        rx_error;
  logic [7:0]  rx_data;
  logic        data_enable;
  logic        fifo_full;
  logic        fifo_write;
  logic [7:0]  fifo_data;
  logic        fifo_pktval;
  logic        fifo_rxact;
  logic [3:0]  pid;
  logic        pid_valid;
  logic        pkt_err;
  logic [15:0] stat_good;
  logic [15:0] stat_err;

  modport master (
    output rx_active, rx_valid, rx_error, rx_data, data_enable, fifo_full,
    input  fifo_write, fifo_data, fifo_pktval, fifo_rxact, pid, pid_valid, pkt_err,
           stat_good, stat_err
  );

  modport slave (
    input  rx_active, rx_valid, rx_error, rx_data, data_enable, fifo_full,
    output fifo_write, fifo_data, fifo_pktval, fifo_rxact, pid, pid_valid, pkt_err,
           stat_good, stat_err
  );
endinterface

// File: rtl/usb_rx_crc16_filter.sv
// USB DATA-packet CRC16 filter: payload reaches the FIFO two bytes late, commit/reject pulses 1 cycle after rx_active falls.
// No UTMI backpressure; fifo_full while writing rejects the packet. USB_RX_STATS_EN adds good/error packet counters.
module usb_rx_crc16_filter #(
  parameter int MAX_PKT = 512,
  parameter int CW      = 10
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  usb_rx_crc16_filter_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_PID, S_DATA, S_DROP} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_LIM = CW'(MAX_PKT + 2);
  localparam logic [CW-1:0] CNT_MIN = CW'(2);
  localparam logic [15:0]   CRC_RES = 16'hB001;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [15:0]   crc_q, crc_d;
  logic [7:0]    hb0_q, hb0_d, hb1_q, hb1_d;
  logic [1:0]    hbn_q, hbn_d;
  logic          err_q, err_d, ovf_q, ovf_d;
  logic          blk_q, blk_d;
  logic [3:0]    pid_q, pid_d;
  logic          pidv_q, pidv_d;
  logic          wr_q, wr_d;
  logic [7:0]    wdat_q, wdat_d;
  logic          pktval_q, pktval_d, pkterr_q, pkterr_d;
  logic          rxact_q;
  logic          pid_ok, full_hit;

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    hb0_d    = hb0_q;
    hb1_d    = hb1_q;
    hbn_d    = hbn_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    pid_d    = pid_q;
    wdat_d   = wdat_q;
    pidv_d   = 1'b0;
    wr_d     = 1'b0;
    pktval_d = 1'b0;
    pkterr_d = 1'b0;
    // after a reset, wait for rx_active low so a half-received packet is never parsed
    blk_d    = blk_q & bus.rx_active;
    pid_ok   = (bus.rx_data[3:0] == ~bus.rx_data[7:4]);
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    full_hit = wr_q & bus.fifo_full;

    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_active && !blk_q) begin
          state_d = S_PID;
          cnt_d   = '0;
          crc_d   = 16'hFFFF;
          hbn_d   = 2'd0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_PID: begin
        if (!bus.rx_active) begin
          state_d = S_IDLE;
        end else if (bus.rx_valid) begin
          if (!pid_ok) begin
            state_d = S_DROP;
          end else begin
            pid_d   = bus.rx_data[3:0];
            pidv_d  = 1'b1;
            // DATA0/1/2/MDATA are exactly the PIDs with low bits 2'b11
            state_d = (bus.data_enable && bus.rx_data[1:0] == 2'b11) ? S_DATA : S_DROP;
          end
        end
      end
      S_DATA: begin
        ovf_d = ovf_q | full_hit;
        err_d = err_q | bus.rx_error;
        if (!bus.rx_active) begin
          state_d = S_IDLE;
          hbn_d   = 2'd0;
          if (cnt_q >= CNT_MIN && crc_q == CRC_RES && !err_d && !ovf_d)
            pktval_d = 1'b1;
          else
            pkterr_d = 1'b1;
        end else if (bus.rx_valid) begin
          cnt_d = cnt_inc;
          crc_d = crc16_upd(crc_q, bus.rx_data);
          hb0_d = bus.rx_data;
          hb1_d = hb0_q;
          if (cnt_inc > CNT_LIM)
            ovf_d = 1'b1;
          if (hbn_q == 2'd2) begin
            if (!ovf_d) begin
              wr_d   = 1'b1;
              wdat_d = hb1_q;
            end
          end else begin
            hbn_d = hbn_q + 1'b1;
          end
        end
      end
      S_DROP: begin
        if (!bus.rx_active)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      crc_q    <= 16'hFFFF;
      hb0_q    <= '0;
      hb1_q    <= '0;
      hbn_q    <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      blk_q    <= 1'b1;
      pid_q    <= '0;
      pidv_q   <= 1'b0;
      wr_q     <= 1'b0;
      wdat_q   <= '0;
      pktval_q <= 1'b0;
      pkterr_q <= 1'b0;
      rxact_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      crc_q    <= crc_d;
      hb0_q    <= hb0_d;
      hb1_q    <= hb1_d;
      hbn_q    <= hbn_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      blk_q    <= blk_d;
      pid_q    <= pid_d;
      pidv_q   <= pidv_d;
      wr_q     <= wr_d;
      wdat_q   <= wdat_d;
      pktval_q <= pktval_d;
      pkterr_q <= pkterr_d;
      rxact_q  <= bus.rx_active;
    end
  end

  assign bus.fifo_write  = wr_q;
  assign bus.fifo_data   = wdat_q;
  assign bus.fifo_pktval = pktval_q;
  assign bus.fifo_rxact  = rxact_q;
  assign bus.pid         = pid_q;
  assign bus.pid_valid   = pidv_q;
  assign bus.pkt_err     = pkterr_q;

`ifdef USB_RX_STATS_EN
  logic [15:0] sgood_q, serr_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sgood_q <= '0;
      serr_q  <= '0;
    end else begin
      if (pktval_q && sgood_q != 16'hFFFF)
        sgood_q <= sgood_q + 1'b1;
      if (pkterr_q && serr_q != 16'hFFFF)
        serr_q <= serr_q + 1'b1;
    end
  end

  assign bus.stat_good = sgood_q;
  assign bus.stat_err  = serr_q;
`else
  assign bus.stat_good = '0;
  assign bus.stat_err  = '0;
`endif
endmodule

// File: tb/tb_usb_rx_crc16_filter.sv
// Randomized scoreboard bench for usb_rx_crc16_filter with a packet-level reference model.
module tb_usb_rx_crc16_filter;
  localparam int MAXP = 4;

  typedef logic [7:0] bq_t[$];
  typedef enum int {EV_PID, EV_WR, EV_GOOD, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] dat;
  } ev_t;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  usb_rx_crc16_filter_if bus();

  usb_rx_crc16_filter #(.MAX_PKT(MAXP), .CW(10)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  ev_t exp_q[$];
  int  errs = 0;
  int  checks = 0;
  int  exp_good = 0;
  int  exp_err = 0;
  int  wr_total = 0;
  int  wr_base = 0;
  int  full_after = 0;
  bit  full_en = 1'b0;

  // fifo_full rises right after the edge that completes write number full_after of the packet
  always @(posedge CLK) if (RSTn && bus.fifo_write) wr_total <= wr_total + 1;
  assign bus.fifo_full = full_en && ((wr_total - wr_base) >= full_after);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic void push_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.dat  = d;
    exp_q.push_back(e);
  endfunction

  task automatic expect_ev(input ev_kind_t k, input logic [7:0] d, input string nm);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errs++;
      $display("FAIL %s: got event data %0h, required no event", nm, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.dat != d) begin
        errs++;
        $display("FAIL %s: got kind %0d data %0h, required kind %0d data %0h", nm, k, d, e.kind, e.dat);
      end
    end
  endtask

  // USB CRC16 as transmitted: complement of the LSB-first 0xA001 remainder seeded with 0xFFFF
  function automatic logic [15:0] usb_crc16(input bq_t msg);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    foreach (msg[i])
      for (int b = 0; b < 8; b++) begin
        fb = r[0] ^ msg[i][b];
        r  = r >> 1;
        if (fb) r = r ^ 16'hA001;
      end
    return ~r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] pidb, input bq_t pl, input bit raw, input bit corrupt,
                          input bit inj_err, input int fa, input int gap, input bit de);
    bq_t         bytes, pay;
    logic [15:0] c;
    bit          pid_ok, bad, inj;
    int          n, l, w, idx;
    bytes = {pidb};
    foreach (pl[i]) bytes.push_back(pl[i]);
    if (!raw) begin
      c = usb_crc16(pl);
      bytes.push_back(c[7:0]);
      bytes.push_back(c[15:8]);
    end
    if (corrupt && bytes.size() > 1) begin
      idx = $urandom_range(1, bytes.size() - 1);
      bytes[idx] = bytes[idx] ^ (8'h01 << $urandom_range(0, 7));
    end
    inj = inj_err && (bytes.size() > 2);

    // reference model: what the packet must produce, from the bytes actually on the wire
    pid_ok = (pidb[3:0] == ~pidb[7:4]);
    if (pid_ok) push_ev(EV_PID, {4'h0, pidb[3:0]});
    if (pid_ok && de && (pidb[3:0] inside {4'h3, 4'h7, 4'hB, 4'hF})) begin
      n = bytes.size() - 1;
      l = (n > 2) ? n - 2 : 0;
      pay.delete();
      for (int i = 0; i < l; i++) pay.push_back(bytes[1 + i]);
      bad = (n < 2) || inj || (l > MAXP);
      if (n >= 2 && {bytes[n], bytes[n-1]} != usb_crc16(pay)) bad = 1'b1;
      w = (l < MAXP) ? l : MAXP;
      if (fa >= 0 && w > fa) begin
        w   = fa + 1;
        bad = 1'b1;
      end
      for (int i = 0; i < w; i++) push_ev(EV_WR, pay[i]);
      if (bad) begin
        push_ev(EV_ERR, 8'h00);
        exp_err++;
      end else begin
        push_ev(EV_GOOD, 8'h00);
        exp_good++;
      end
    end

    wr_base         = wr_total;
    full_after      = (fa >= 0) ? fa : 0;
    full_en         = (fa >= 0);
    bus.data_enable = de;
    bus.rx_active   = 1'b1;
    tick();
    foreach (bytes[i]) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = bytes[i];
      tick();
      bus.rx_valid = 1'b0;
      if (inj && i == 2) begin
        bus.rx_error = 1'b1;
        tick();
        bus.rx_error = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        tick();
      end
    end
    bus.rx_active = 1'b0;
    bus.rx_data   = 8'($urandom);
    tick();
    full_en = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_fifo_write"},  32'(bus.fifo_write),  32'h0);
    check({tag, "_fifo_data"},   32'(bus.fifo_data),   32'h0);
    check({tag, "_fifo_pktval"}, 32'(bus.fifo_pktval), 32'h0);
    check({tag, "_fifo_rxact"},  32'(bus.fifo_rxact),  32'h0);
    check({tag, "_pid"},         32'(bus.pid),         32'h0);
    check({tag, "_pid_valid"},   32'(bus.pid_valid),   32'h0);
    check({tag, "_pkt_err"},     32'(bus.pkt_err),     32'h0);
  endtask

  // monitor: every DUT pulse must match the head of the scoreboard
  initial begin
    logic prev_act;
    bit   prev_rst;
    prev_act = 1'b0;
    prev_rst = 1'b0;
    forever begin
      @(negedge CLK);
      if (RSTn) begin
        if (prev_rst) check("fifo_rxact_delay", 32'(bus.fifo_rxact), 32'(prev_act));
        if (bus.pid_valid)   expect_ev(EV_PID, {4'h0, bus.pid}, "pid_valid");
        if (bus.fifo_write)  expect_ev(EV_WR, bus.fifo_data, "fifo_write");
        if (bus.fifo_pktval) begin
          expect_ev(EV_GOOD, 8'h00, "fifo_pktval");
          check("pktval_without_write", 32'(bus.fifo_write), 32'h0);
        end
        if (bus.pkt_err)     expect_ev(EV_ERR, 8'h00, "pkt_err");
      end
      prev_act = bus.rx_active;
      prev_rst = RSTn;
    end
  end

  initial begin
    bq_t  pl;
    logic [7:0] pids[9];
    logic [7:0] pb;
    int   len;
    pids = '{8'hC3, 8'h4B, 8'h87, 8'h0F, 8'h69, 8'hE1, 8'h2D, 8'hC2, 8'h00};

    bus.rx_active   = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_error    = 1'b0;
    bus.rx_data     = 8'h00;
    bus.data_enable = 1'b1;
    repeat (3) tick();
    reset_outputs_zero("por");
    RSTn = 1'b1;
    repeat (2) tick();

    // empty DATA1, payload DATA0, CRC error, token, bad PID
    pl = {};                         send_pkt(8'h4B, pl, 0, 0, 0, -1, 2, 1);
    pl = {8'h01, 8'h02, 8'h03};      send_pkt(8'hC3, pl, 0, 0, 0, -1, 2, 1);
    pl = {8'h00, 8'h01};             send_pkt(8'hC3, pl, 1, 0, 0, -1, 2, 1);
    pl = {8'h00, 8'h10};             send_pkt(8'h69, pl, 1, 0, 0, -1, 2, 1);
    pl = {8'h11, 8'h22, 8'h33};      send_pkt(8'hC2, pl, 1, 0, 0, -1, 2, 1);
    // overflow by length, then by fifo_full after the first write
    pl = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    send_pkt(8'hC3, pl, 0, 0, 0, -1, 2, 1);
    pl = {8'hB0, 8'hB1, 8'hB2};      send_pkt(8'hC3, pl, 0, 0, 0, 1, 2, 1);
    // data_enable low, rx_error, then back-to-back packets
    pl = {8'h55};                    send_pkt(8'hC3, pl, 0, 0, 0, -1, 2, 0);
    pl = {8'h01, 8'h02};             send_pkt(8'h4B, pl, 0, 0, 1, -1, 1, 1);
    pl = {8'h7E};                    send_pkt(8'hC3, pl, 0, 0, 0, -1, 1, 1);
    pl = {8'h7F, 8'h80};             send_pkt(8'h4B, pl, 0, 0, 0, -1, 2, 1);

    // reset after the second payload byte
    push_ev(EV_PID, 8'h03);
    bus.data_enable = 1'b1;
    bus.rx_active   = 1'b1;
    tick();
    foreach (pids[i]) if (i < 3) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = (i == 0) ? 8'hC3 : 8'(8'h10 * i);
      tick();
    end
    bus.rx_valid = 1'b0;
    RSTn = 1'b0;
    #1;
    reset_outputs_zero("mid_rst");
    tick();
    RSTn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'(8'h31 + i);
      tick();
    end
    bus.rx_valid  = 1'b0;
    bus.rx_active = 1'b0;
    repeat (2) tick();
    pl = {8'hD0, 8'hD1};             send_pkt(8'hC3, pl, 0, 0, 0, -1, 2, 1);

    for (int k = 0; k < 40; k++) begin
      pb = pids[$urandom_range(0, 8)];
      if (pb == 8'h00) pb = 8'($urandom);
      len = $urandom_range(0, 7);
      pl = {};
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      send_pkt(pb, pl, 0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1,
               $urandom_range(1, 3), ($urandom_range(0, 7) != 0));
    end

    repeat (5) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
`ifdef USB_RX_STATS_EN
    check("stat_good", 32'(bus.stat_good), 32'(exp_good));
    check("stat_err",  32'(bus.stat_err),  32'(exp_err));
`else
    check("stat_good_tied", 32'(bus.stat_good), 32'h0);
    check("stat_err_tied",  32'(bus.stat_err),  32'h0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/usb_rx_crc16_filter.md
USB_RX_CRC16_FILTER -- requirements
Module: usb_rx_crc16_filter

Interface
REQ-001 SHALL have parameter MAX_PKT, default 512: maximum DATA payload bytes, excluding PID and CRC16.
REQ-002 SHALL have parameter CW, default 10: byte-counter width; legal when 2^CW > MAX_PKT+2.
REQ-003 CLK  in  1  clock; all logic on rising edge.
REQ-004 RSTn  in  1  reset, asynchronous, active-low.
REQ-005 rx_active  in  1  UTMI receive active.
REQ-006 rx_valid  in  1  rx_data qualifier.
REQ-007 rx_error  in  1  UTMI receive error.
REQ-008 rx_data  in  8  received byte, PID first.
REQ-009 data_enable  in  1  1 = DATA packets are for this function; sampled at the PID byte.
REQ-010 fifo_full  in  1  full flag from the downstream packet FIFO.
REQ-011 fifo_write  out  1  FIFO write strobe.
REQ-012 fifo_data  out  8  payload byte.
REQ-013 fifo_pktval  out  1  one-cycle commit of the packet written since the last fifo_rxact rise.
REQ-014 fifo_rxact  out  1  registered rx_active; its rise rolls the FIFO back to the last commit.
REQ-015 pid  out  4  last PID, low nibble.
REQ-016 pid_valid  out  1  one-cycle pulse when a PID passes the check.
REQ-017 pkt_err  out  1  one-cycle pulse when an accepted DATA packet is rejected.

Function
REQ-018 FSM states: IDLE, PID, DATA, DROP. Encoding is free.
REQ-019 IDLE->PID on rx_active=1; PID/DATA/DROP->IDLE on rx_active=0.
REQ-020 PID state, first rx_valid byte:
- if rx_data[3:0]==~rx_data[7:4]: pid<=rx_data[3:0] and pid_valid pulses next cycle;
- if the check fails: go to DROP, no pid_valid.
REQ-021 Valid PID in {0x3,0xB,0x7,0xF} with data_enable=1 goes to DATA; any other valid PID goes to DROP.
REQ-022 DATA: every rx_valid byte updates CRC16 (reflected poly 0xA001, LSB-first, init 0xFFFF) and enters a 2-byte holdback pipeline.
REQ-023 Once the holdback holds 2 bytes, each new byte causes fifo_write=1 the next cycle, with fifo_data = the byte accepted two bytes earlier. CRC bytes are therefore never written.
REQ-024 The byte counter counts DATA bytes and saturates at 2^CW-1.
REQ-025 Overflow flag is set when the count exceeds MAX_PKT+2, or when fifo_write=1 while fifo_full=1. Once set, further fifo_write is suppressed.
REQ-026 rx_error=1 in DATA sets an error flag; the state stays DATA until rx_active=0.
REQ-027 rx_active=0 in DATA: the cycle after, exactly one of the following pulses; the held-back bytes are then discarded.
- fifo_pktval, when count>=2, CRC register==0xB001, and no error or overflow flag;
- pkt_err otherwise.
REQ-028 fifo_pktval never coincides with fifo_write; the last payload write precedes it by at least 1 cycle.
REQ-029 DROP and PID exit on rx_active=0 with no pkt_err and no fifo_pktval.
REQ-030 fifo_rxact = rx_active delayed one cycle, in every state.
REQ-031 A new rx_active=1 in the cycle immediately after a fall is handled normally: the pending pulse still issues and the FSM enters PID.

Reset
REQ-032 RSTn=0 SHALL immediately force:
- FSM to IDLE;
- counter, flags and holdback cleared, CRC register to 0xFFFF;
- all outputs to 0, pid included.
REQ-033 A reset mid-packet SHALL emit no pulses. Remaining bytes are ignored until the next rx_active rise after reset release.

Configuration
REQ-034 Macro USB_RX_STATS_EN defined: adds outputs stat_good[15:0] and stat_err[15:0].
- saturating counts of fifo_pktval and pkt_err pulses;
- reset to 0.
REQ-035 Macro undefined: both ports still exist, tied to 0, and no counter logic is built.

Verification
REQ-036 Good DATA: 0x4B,0x00,0x00, data_enable=1.
- fifo_pktval=1 once, no fifo_write, pid=0xB, pid_valid once.
REQ-037 Good DATA with payload: 0xC3,0x01,0x02,0x03 plus correct CRC16.
- fifo_write three times with 0x01,0x02,0x03, then fifo_pktval; pkt_err=0.
REQ-038 CRC error: 0xC3,0x00,0x01.
- pkt_err once, no fifo_pktval;
- with USB_RX_STATS_EN, stat_err=1.
REQ-039 Token and bad PID.
- 0x69,0x00,0x10: pid_valid, pid=0x9, no FIFO activity;
- 0xC2,...: no pid_valid, no pulses.
REQ-040 Overflow: MAX_PKT=4, packet 0xC3 plus 6 bytes plus valid CRC.
- at most 4 writes, then pkt_err;
- repeat with fifo_full=1 after the 1st write: pkt_err.
REQ-041 Reset: RSTn low after the 2nd payload byte.
- all outputs 0, no pulses;
- the next good packet commits normally.
